// File: rtl/matrix_issue_sequencer_if.sv
// Command, element-load and issue signals between a feeder and the matrix issue sequencer.
// Latency: none (wires only); the sequencer owns all timing.
// Backpressure: cmd_ready / in_ready gate the feeder, issue side has none.
interface matrix_issue_sequencer_if #(
   parameter int W = 32
);
   logic         cmd_valid;
   logic [5:0]   cmd_op;
   logic         cmd_ready;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         abort;
   logic [5:0]   sel;
   logic [W-1:0] eleIn;
   logic         issue_valid;
   logic         done;
   logic         err;

   // Feeder side: offers commands and elements, observes issue and completion.
   modport master (
      output cmd_valid, cmd_op, in_valid, in_data, abort,
      input  cmd_ready, in_ready, sel, eleIn, issue_valid, done, err
   );

   // Sequencer side.
   modport slave (
      input  cmd_valid, cmd_op, in_valid, in_data, abort,
      output cmd_ready, in_ready, sel, eleIn, issue_valid, done, err
   );
endinterface

// File: rtl/matrix_issue_sequencer.sv
// Buffers N_ELEM operand elements per command, then issues them in order with the latched op.
// Latency: first issue 1 cycle after last element accept; accept-to-done 2*N_ELEM+2 cycles.
// Backpressure: cmd_ready only in IDLE, in_ready only in LOAD; issue phase cannot be stalled.
module matrix_issue_sequencer #(
   parameter int N_ELEM = 18,
   parameter int W      = 32
) (
   input logic                     clk,
   input logic                     reset,
   matrix_issue_sequencer_if.slave bus
);
   localparam int IW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_ELEM - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;

   logic [1:0]    state;
   // One index serves both phases: load position in LOAD, issue position in ISSUE.
   logic [IW-1:0] idx;
   logic [5:0]    op_q;
   logic          done_q;
   logic          err_q;
   logic [W-1:0]  buffer [N_ELEM];

   logic in_acc;
   assign in_acc = (state == S_LOAD) && bus.in_valid && !bus.abort;

   // Sequencer FSM: command accept, element load, issue sweep, done/err pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         idx    <= '0;
         op_q   <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  if (bus.cmd_op != 6'd0) begin
                     op_q  <= bus.cmd_op;
                     idx   <= '0;
                     state <= S_LOAD;
                  end else begin
                     // Op 0 is not a valid ALU operation: reject without loading.
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (bus.abort) begin
                  state  <= S_IDLE;
                  idx    <= '0;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end else if (bus.in_valid) begin
                  if (idx == LAST_IDX) begin
                     state <= S_ISSUE;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (bus.abort) begin
                  state  <= S_IDLE;
                  idx    <= '0;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end else if (idx == LAST_IDX) begin
                  state  <= S_IDLE;
                  idx    <= '0;
                  done_q <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

   // Element buffer: written only on a non-aborted accept; never cleared, every slot is
   // rewritten by the load phase before the issue phase reads it.
   always_ff @(posedge clk) begin
      if (in_acc) begin
         buffer[idx] <= bus.in_data;
      end
   end

   // Handshakes and issue outputs decode straight from state so reset clears them at once.
   assign bus.cmd_ready   = (state == S_IDLE);
   assign bus.in_ready    = (state == S_LOAD);
   assign bus.issue_valid = (state == S_ISSUE);
   assign bus.sel         = (state == S_ISSUE) ? op_q : 6'd0;
   assign bus.eleIn       = (state == S_ISSUE) ? buffer[idx] : '0;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
endmodule

// File: tb/tb_matrix_issue_sequencer.sv
// Directed bench for matrix_issue_sequencer: streaming, stalls, reject, abort, reset, hold.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
// Each scenario task checks its own hand-computed expectations.
module tb_matrix_issue_sequencer;
   localparam int N = 18;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   matrix_issue_sequencer_if #(.W(32)) bus ();
   matrix_issue_sequencer #(.N_ELEM(N), .W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

   int total = 0;
   int bad   = 0;

   // Observations recorded by run_cmd; cycle 1 is the command-accept cycle.
   int         r_issued[$];
   int         r_sel_bad, r_first_issue, r_last_acc, r_done_cyc, r_err, r_in_ready_seen;
   logic [6:0] r_rst_outs;
   int         r_rst_done;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stimulus driver: offers one command then streams elements, recording what it sees.
   task automatic run_cmd(input logic [5:0] op, input int base, input bit gap,
                          input int abort_at, input int rst_at);
      int n_acc;
      n_acc = 0;
      r_issued.delete();
      r_sel_bad = 0; r_first_issue = -1; r_last_acc = -1;
      r_done_cyc = -1; r_err = -1; r_in_ready_seen = 0;
      r_rst_outs = '1; r_rst_done = -1;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 6'd0;
      for (int cyc = 2; cyc < 150; cyc++) begin
         if (bus.in_ready === 1'b1) r_in_ready_seen++;
         if (bus.issue_valid === 1'b1) begin
            if (r_first_issue < 0) r_first_issue = cyc;
            if (bus.sel !== op) r_sel_bad++;
            r_issued.push_back(int'(bus.eleIn));
         end
         if (bus.done === 1'b1) begin
            r_done_cyc = cyc;
            r_err      = int'(bus.err);
            break;
         end
         if (rst_at >= 0 && bus.issue_valid === 1'b1 && r_issued.size() == rst_at + 1) begin
            #2 reset = 1'b0;
            #1;
            r_rst_outs = {bus.cmd_ready, bus.in_ready, bus.issue_valid,
                          bus.sel != 6'd0, bus.eleIn != 32'd0, bus.done, bus.err};
            r_rst_done = 0;
            repeat (3) begin
               tick();
               if (bus.done !== 1'b0) r_rst_done++;
            end
            reset = 1'b1;
            tick();
            break;
         end
         bus.in_valid = (n_acc < N) && (!gap || (cyc % 2 == 0));
         bus.in_data  = 32'(base + n_acc);
         bus.abort    = (abort_at >= 0) && (n_acc == abort_at) && bus.in_valid && bus.in_ready;
         if (bus.in_valid && bus.in_ready) begin
            n_acc++;
            r_last_acc = cyc;
         end
         tick();
         bus.in_valid = 1'b0;
         bus.abort    = 1'b0;
      end
      bus.in_valid = 1'b0;
      bus.in_data  = 32'd0;
      bus.abort    = 1'b0;
   endtask

   task automatic test_reset();
      bus.cmd_valid = 1'b0; bus.cmd_op = 6'd0; bus.in_valid = 1'b0;
      bus.in_data = 32'd0; bus.abort = 1'b0;
      reset = 1'b0;
      #48;
      total++;
      if ({bus.cmd_ready, bus.in_ready, bus.issue_valid, bus.done, bus.err} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=10000",
                  {bus.cmd_ready, bus.in_ready, bus.issue_valid, bus.done, bus.err});
      end
      total++;
      if (bus.sel !== 6'd0 || bus.eleIn !== 32'd0) begin
         bad++;
         $display("FAIL reset_data sel=%0d eleIn=%0d want 0/0", bus.sel, bus.eleIn);
      end
      #2 reset = 1'b1;
      tick();
   endtask

   task automatic test_stream();
      run_cmd(6'd18, 30, 1'b0, -1, -1);
      total++;
      if (r_issued.size() != N) begin
         bad++; $display("FAIL stream_count got=%0d want=%0d", r_issued.size(), N);
      end
      for (int i = 0; i < r_issued.size() && i < N; i++) begin
         total++;
         if (r_issued[i] != 30 + i) begin
            bad++; $display("FAIL stream_elem[%0d] got=%0d want=%0d", i, r_issued[i], 30 + i);
         end
      end
      total++;
      if (r_sel_bad != 0) begin bad++; $display("FAIL stream_sel bad_cycles=%0d want=0", r_sel_bad); end
      total++;
      if (r_first_issue != 20) begin
         bad++; $display("FAIL stream_first_issue got=%0d want=20", r_first_issue);
      end
      total++;
      if (r_done_cyc != 38 || r_err != 0) begin
         bad++; $display("FAIL stream_done cyc=%0d err=%0d want 38/0", r_done_cyc, r_err);
      end
   endtask

   task automatic test_stall();
      run_cmd(6'd18, 30, 1'b1, -1, -1);
      total++;
      if (r_issued.size() != N) begin
         bad++; $display("FAIL stall_count got=%0d want=%0d", r_issued.size(), N);
      end
      for (int i = 0; i < r_issued.size() && i < N; i++) begin
         total++;
         if (r_issued[i] != 30 + i) begin
            bad++; $display("FAIL stall_elem[%0d] got=%0d want=%0d", i, r_issued[i], 30 + i);
         end
      end
      total++;
      if (r_last_acc != 36 || r_first_issue != 37) begin
         bad++; $display("FAIL stall_latency last_acc=%0d first_issue=%0d want 36/37",
                         r_last_acc, r_first_issue);
      end
      total++;
      if (r_done_cyc != 55 || r_err != 0) begin
         bad++; $display("FAIL stall_done cyc=%0d err=%0d want 55/0", r_done_cyc, r_err);
      end
   endtask

   task automatic test_zero_op();
      run_cmd(6'd0, 0, 1'b0, -1, -1);
      total++;
      if (r_done_cyc != 2 || r_err != 1) begin
         bad++; $display("FAIL zero_op_done cyc=%0d err=%0d want 2/1", r_done_cyc, r_err);
      end
      total++;
      if (r_in_ready_seen != 0 || r_issued.size() != 0) begin
         bad++; $display("FAIL zero_op_quiet in_ready=%0d issues=%0d want 0/0",
                         r_in_ready_seen, r_issued.size());
      end
   endtask

   task automatic test_abort();
      run_cmd(6'd7, 50, 1'b0, 4, -1);
      total++;
      if (r_last_acc != 6 || r_done_cyc != 7 || r_err != 1) begin
         bad++; $display("FAIL abort_done abort_cyc=%0d done=%0d err=%0d want 6/7/1",
                         r_last_acc, r_done_cyc, r_err);
      end
      total++;
      if (r_issued.size() != 0) begin
         bad++; $display("FAIL abort_no_issue got=%0d want=0", r_issued.size());
      end
      run_cmd(6'd9, 100, 1'b0, -1, -1);
      total++;
      if (r_issued.size() != N || r_sel_bad != 0) begin
         bad++; $display("FAIL after_abort_count got=%0d selbad=%0d want %0d/0",
                         r_issued.size(), r_sel_bad, N);
      end
      for (int i = 0; i < r_issued.size() && i < N; i++) begin
         total++;
         if (r_issued[i] != 100 + i) begin
            bad++; $display("FAIL after_abort_elem[%0d] got=%0d want=%0d", i, r_issued[i], 100 + i);
         end
      end
      total++;
      if (r_done_cyc != 38 || r_err != 0) begin
         bad++; $display("FAIL after_abort_done cyc=%0d err=%0d want 38/0", r_done_cyc, r_err);
      end
   endtask

   task automatic test_abort_idle();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      total++;
      if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         bad++; $display("FAIL abort_idle done=%b cmd_ready=%b want 0/1", bus.done, bus.cmd_ready);
      end
   endtask

   task automatic test_reset_mid_issue();
      run_cmd(6'd3, 200, 1'b0, -1, 7);
      total++;
      if (r_rst_outs !== 7'b1000000) begin
         bad++; $display("FAIL rst_issue_outs got=%b want=1000000", r_rst_outs);
      end
      total++;
      if (r_rst_done != 0 || r_done_cyc != -1) begin
         bad++; $display("FAIL rst_issue_no_done pulses=%0d done_cyc=%0d want 0/-1",
                         r_rst_done, r_done_cyc);
      end
      run_cmd(6'd4, 300, 1'b0, -1, -1);
      total++;
      if (r_done_cyc != 38 || r_err != 0 || r_issued.size() != N) begin
         bad++; $display("FAIL rst_recover cyc=%0d err=%0d issues=%0d want 38/0/%0d",
                         r_done_cyc, r_err, r_issued.size(), N);
      end
      for (int i = 0; i < r_issued.size() && i < N; i++) begin
         total++;
         if (r_issued[i] != 300 + i) begin
            bad++; $display("FAIL rst_recover_elem[%0d] got=%0d want=%0d", i, r_issued[i], 300 + i);
         end
      end
   endtask

   task automatic test_cmd_hold();
      int busy_rdy;
      int done_cyc;
      int n_acc;
      busy_rdy = 0; done_cyc = -1; n_acc = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 6'd5;
      tick();
      for (int cyc = 2; cyc < 80; cyc++) begin
         if (bus.done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
         if (bus.cmd_ready !== 1'b0) busy_rdy++;
         bus.in_valid = (n_acc < N);
         bus.in_data  = 32'(400 + n_acc);
         if (bus.in_valid && bus.in_ready) n_acc++;
         tick();
      end
      bus.in_valid = 1'b0;
      total++;
      if (busy_rdy != 0) begin bad++; $display("FAIL hold_busy_ready cycles=%0d want=0", busy_rdy); end
      total++;
      if (done_cyc != 38 || bus.cmd_ready !== 1'b1) begin
         bad++; $display("FAIL hold_done cyc=%0d cmd_ready=%b want 38/1", done_cyc, bus.cmd_ready);
      end
      tick();
      bus.cmd_valid = 1'b0;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL hold_reaccept in_ready=%b want=1", bus.in_ready);
      end
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      total++;
      if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.cmd_ready !== 1'b1) begin
         bad++; $display("FAIL hold_abort_load done=%b err=%b rdy=%b want 1/1/1",
                         bus.done, bus.err, bus.cmd_ready);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_zero_op();
      test_abort();
      test_abort_idle();
      test_reset_mid_issue();
      test_cmd_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
